// File: rtl/lsu_core_bridge.sv
// lsu_core_bridge: core data port to word memory bus (byte lanes, store replication, load extension, fault detection).
// Latency: 3 cycles minimum (IDLE, BUSY with ready, RESP), +1 per memory wait cycle; illegal accesses answer in RESP after 2.
// Backpressure: core held by core_stall_o until RESP; memory stretches BUSY via mem_ready_i. LSU_TIMEOUT_EN aborts after TIMEOUT_CYCLES.
module lsu_core_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    state_t      state;
    logic [2:0]  lat_size;
    logic        req_legal;
    logic [3:0]  st_be;
    logic [31:0] st_wd;
    logic [31:0] ld_shift;
    logic [31:0] ld_dat;
    logic        timeout_hit;

    // Legality and store lane formatting; BU/HU stores behave like B/H.
    always_comb begin
        req_legal = 1'b0;
        st_be     = 4'hF;
        st_wd     = core_wd_i;
        case (core_size_i)
            SZ_B, SZ_BU: begin
                req_legal = 1'b1;
                if (core_we_i) begin
                    st_be = 4'b0001 << core_addr_i[1:0];
                    st_wd = {4{core_wd_i[7:0]}};
                end
            end
            SZ_H, SZ_HU: begin
                req_legal = ~core_addr_i[0];
                if (core_we_i) begin
                    st_be = core_addr_i[1] ? 4'b1100 : 4'b0011;
                    st_wd = {2{core_wd_i[15:0]}};
                end
            end
            SZ_W:    req_legal = (core_addr_i[1:0] == 2'b00);
            default: req_legal = 1'b0;
        endcase
    end

    // Aligned accesses let one shift bring the addressed byte or half down to bit 0.
    always_comb begin
        ld_shift = mem_rd_i >> {mem_addr_o[1:0], 3'b000};
        case (lat_size)
            SZ_B:    ld_dat = {{24{ld_shift[7]}}, ld_shift[7:0]};
            SZ_BU:   ld_dat = {24'h0, ld_shift[7:0]};
            SZ_H:    ld_dat = {{16{ld_shift[15]}}, ld_shift[15:0]};
            SZ_HU:   ld_dat = {16'h0, ld_shift[15:0]};
            default: ld_dat = mem_rd_i;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] busy_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_cnt <= '0;
        end else if (state != BUSY) begin
            busy_cnt <= '0;
        end else if (!mem_ready_i) begin
            busy_cnt <= busy_cnt + 1'b1;
        end
    end

    // Ready on the limit cycle still completes normally.
    assign timeout_hit = (state == BUSY) && !mem_ready_i &&
                         (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        case (state)
            IDLE:    core_stall_o = core_req_i;
            BUSY:    core_stall_o = 1'b1;
            default: core_stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            lat_size   <= 3'd0;
            core_rd_o  <= 32'h0;
            fault_o    <= 1'b0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= 4'h0;
            mem_addr_o <= 32'h0;
            mem_wd_o   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    fault_o <= 1'b0;
                    if (core_req_i) begin
                        if (req_legal) begin
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= core_we_i;
                            mem_be_o   <= st_be;
                            mem_addr_o <= core_addr_i;
                            mem_wd_o   <= st_wd;
                            lat_size   <= core_size_i;
                            state      <= BUSY;
                        end else begin
                            core_rd_o <= 32'h0;
                            fault_o   <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready_i) begin
                        if (!mem_we_o) begin
                            core_rd_o <= ld_dat;
                        end
                        mem_req_o <= 1'b0;
                        state     <= RESP;
                    end else if (timeout_hit) begin
                        mem_req_o <= 1'b0;
                        core_rd_o <= 32'h0;
                        fault_o   <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    fault_o <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    fault_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_core_bridge.sv
// Scoreboard bench for lsu_core_bridge: expectations queued at issue, checked at the memory side and at RESP.
module tb_lsu_core_bridge;

    localparam int TB_TO = 4;
`ifdef LSU_TIMEOUT_EN
    localparam int TO_LIM = TB_TO;
`else
    localparam int TO_LIM = 1 << 30;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'd0;
    logic [31:0] core_addr_i = 32'h0;
    logic [31:0] core_wd_i = 32'h0;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        fault_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i = 32'h0;
    logic        mem_ready_i = 1'b0;

    lsu_core_bridge #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .fault_o      (fault_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rd;
        logic        fault;
        logic        mem;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    logic        saw_req = 1'b0;
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Memory side and response side checks against the queue head.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (mem_req_o && sbq.size() > 0) begin
                saw_req = 1'b1;
                chk("mem_we", mem_we_o, sbq[0].we);
                chk("mem_be", mem_be_o, sbq[0].be);
                chk("mem_addr", mem_addr_o, sbq[0].addr);
                if (sbq[0].we) chk("mem_wd", mem_wd_o, sbq[0].wd);
            end
            if (core_req_i && !core_stall_o && sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("core_rd", core_rd_o, mon_e.rd);
                chk("fault", fault_o, mon_e.fault);
                chk("mem_issued", saw_req, mon_e.mem);
                saw_req = 1'b0;
            end
        end
    end

    task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rdata, input int delay);
        exp_t        e;
        logic        legal;
        logic        to;
        logic [31:0] sh;
        logic [31:0] fmt;
        int          n;
        int          busy;
        int          exp_busy;
        case (size)
            3'd0, 3'd4: legal = 1'b1;
            3'd1, 3'd5: legal = (addr[0] == 1'b0);
            3'd2:       legal = (addr[1:0] == 2'b00);
            default:    legal = 1'b0;
        endcase
        to = legal && (delay >= TO_LIM);
        e.mem  = legal;
        e.we   = we;
        e.addr = addr;
        e.be   = 4'hF;
        e.wd   = wd;
        if (we && (size == 3'd0 || size == 3'd4)) begin
            e.be = 4'b0001 << addr[1:0];
            e.wd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        end else if (we && (size == 3'd1 || size == 3'd5)) begin
            e.be = addr[1] ? 4'b1100 : 4'b0011;
            e.wd = {wd[15:0], wd[15:0]};
        end
        sh = rdata >> (8 * addr[1:0]);
        case (size)
            3'd0:    fmt = sh[7] ? (32'hFFFFFF00 | sh[7:0]) : {24'h0, sh[7:0]};
            3'd4:    fmt = {24'h0, sh[7:0]};
            3'd1:    fmt = sh[15] ? (32'hFFFF0000 | sh[15:0]) : {16'h0, sh[15:0]};
            3'd5:    fmt = {16'h0, sh[15:0]};
            default: fmt = rdata;
        endcase
        if (!legal || to) begin
            e.fault = 1'b1;
            e.rd    = 32'h0;
        end else begin
            e.fault = 1'b0;
            e.rd    = we ? last_rd : fmt;
        end
        last_rd  = e.rd;
        exp_busy = !legal ? 0 : (to ? TO_LIM : delay + 1);
        sbq.push_back(e);

        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_rd_i    = rdata;
        mem_ready_i = 1'b0;
        #1 chk("stall_idle", core_stall_o, 1'b1);
        n    = 0;
        busy = 0;
        while (1) begin
            if (mem_req_o) begin
                busy++;
                mem_ready_i = (busy > delay);
            end else begin
                mem_ready_i = 1'b0;
            end
            @(posedge clk_i); #1;
            n++;
            if (!core_stall_o) break;
            if (n > 64) break;
        end
        chk("latency", n, exp_busy + 1);
        chk("busy_cycles", busy, exp_busy);
        @(posedge clk_i); #1;
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
        #1;
        chk("stall_rel", core_stall_o, 1'b0);
        chk("fault_pulse", fault_o, 1'b0);
        chk("req_idle", mem_req_o, 1'b0);
    endtask

    task automatic reset_mid_access();
        int busy;
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h200;
        mem_rd_i    = 32'h55AA55AA;
        mem_ready_i = 1'b0;
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
            if (mem_req_o) busy++;
            if (busy == 3) break;
        end
        chk("rst_busy", busy, 3);
        rst_i = 1'b0;
        #1;
        chk("rst_req", mem_req_o, 1'b0);
        chk("rst_rd", core_rd_o, 32'h0);
        chk("rst_fault", fault_o, 1'b0);
        chk("rst_be", mem_be_o, 4'h0);
        chk("rst_stall_req", core_stall_o, 1'b1);
        core_req_i = 1'b0;
        #1 chk("rst_stall_idle", core_stall_o, 1'b0);
        saw_req = 1'b0;
        last_rd = 32'h0;
        #1 rst_i = 1'b1;
    endtask

    logic [2:0] szs [6];

    initial begin
        szs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
        #12;
        chk("reset_rd", core_rd_o, 32'h0);
        chk("reset_req", mem_req_o, 1'b0);
        chk("reset_we", mem_we_o, 1'b0);
        chk("reset_be", mem_be_o, 4'h0);
        chk("reset_addr", mem_addr_o, 32'h0);
        chk("reset_wd", mem_wd_o, 32'h0);
        chk("reset_fault", fault_o, 1'b0);
        chk("reset_stall0", core_stall_o, 1'b0);
        core_req_i = 1'b1;
        #1 chk("reset_stall1", core_stall_o, 1'b1);
        core_req_i = 1'b0;
        #2 rst_i = 1'b1;

        do_access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        do_access(1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0);
        do_access(1'b0, 3'd0, 32'h2, 32'h0, 32'h80FF7F01, 0);
        do_access(1'b0, 3'd4, 32'h3, 32'h0, 32'h80FF7F01, 1);
        do_access(1'b0, 3'd1, 32'h2, 32'h0, 32'h80FF7F01, 0);
        do_access(1'b0, 3'd5, 32'h0, 32'h0, 32'h80FF7F01, 2);
        do_access(1'b0, 3'd0, 32'h1, 32'h0, 32'h00007F00, 0);
        do_access(1'b0, 3'd2, 32'h102, 32'h0, 32'h12345678, 0);
        do_access(1'b1, 3'd1, 32'h102, 32'h1234BEEF, 32'h0, 2);
        do_access(1'b1, 3'd2, 32'h104, 32'hCAFEF00D, 32'h0, 3);
        do_access(1'b0, 3'd3, 32'h0, 32'h0, 32'h11111111, 0);
        do_access(1'b0, 3'd1, 32'h1, 32'h0, 32'h22222222, 0);
        do_access(1'b0, 3'd2, 32'h40, 32'h0, 32'hA1B2C3D4, 1);

        reset_mid_access();
        do_access(1'b0, 3'd2, 32'h204, 32'h0, 32'h0BADF00D, 0);

`ifdef LSU_TIMEOUT_EN
        do_access(1'b0, 3'd2, 32'h300, 32'h0, 32'h12345678, 100);
`endif

        for (int i = 0; i < 24; i++) begin
            do_access(1'($urandom_range(0, 1)), szs[$urandom_range(0, 5)], $urandom,
                      $urandom, $urandom, $urandom_range(0, 3));
        end

        repeat (2) @(posedge clk_i);
        #1 chk("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
